// File: rtl/handshake_protocol_monitor.sv
// Passive checker for NUM_CH independent ready/valid channels: counts transfers,
// flags valid drops, payload changes and over-long stalls as sticky per-channel errors.
module handshake_protocol_monitor #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_STALL  = 15,
  localparam int FW        = $clog2(NUM_CH) + 1
) (
  input  logic                           CLK,
  input  logic                           ASYNCRESETN,
  input  logic                           clear,
  input  logic [NUM_CH-1:0]              valid,
  input  logic [NUM_CH-1:0]              ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   data,
  output logic [NUM_CH*CNT_WIDTH-1:0]    xfer_count,
  output logic [NUM_CH-1:0]              err_valid_drop,
  output logic [NUM_CH-1:0]              err_data_change,
  output logic [NUM_CH-1:0]              err_stall,
  output logic                           err_any,
  output logic [FW-1:0]                  first_err_ch
);

  // Handshake: a transfer happens on any cycle with valid&ready; once valid is
  // raised without ready, valid must stay high and data must stay constant until ready.
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} ch_state_t;

  localparam logic [7:0]    MAX_ST = 8'(MAX_STALL);
  localparam logic [FW-1:0] NONE   = '1;

  // state_q is the per-channel FSM state, left visible for hierarchical probing.
  ch_state_t             state_q [NUM_CH];
  ch_state_t             state_d [NUM_CH];
  logic [7:0]            stall_q [NUM_CH];
  logic [7:0]            stall_d [NUM_CH];
  logic [DATA_WIDTH-1:0] held_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] held_d  [NUM_CH];

  logic [NUM_CH-1:0]           ev_drop, ev_dchg, ev_stall, ev_any;
  logic [NUM_CH-1:0]           drop_d, dchg_d, stall_err_d;
  logic [NUM_CH*CNT_WIDTH-1:0] count_d;
  logic [FW-1:0]               first_d;

  always_comb begin
    ev_drop  = '0;
    ev_dchg  = '0;
    ev_stall = '0;
    count_d  = xfer_count;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      stall_d[i] = stall_q[i];
      held_d[i]  = held_q[i];
      case (state_q[i])
        IDLE: begin
          if (valid[i] && !ready[i]) begin
            state_d[i] = PEND;
            stall_d[i] = 8'd1;
            held_d[i]  = data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        PEND: begin
          if (!valid[i]) begin
            ev_drop[i] = 1'b1;
            state_d[i] = IDLE;
            stall_d[i] = 8'd0;
          end else begin
            ev_dchg[i] = (data[i*DATA_WIDTH +: DATA_WIDTH] != held_q[i]);
            if (ready[i]) begin
              state_d[i] = IDLE;
              stall_d[i] = 8'd0;
            end else begin
              ev_stall[i] = (stall_q[i] >= MAX_ST);
              if (stall_q[i] != 8'hFF) stall_d[i] = stall_q[i] + 8'd1;
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
      if (clear)
        count_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
      else if (valid[i] && ready[i])
        count_d[i*CNT_WIDTH +: CNT_WIDTH] = xfer_count[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
    end

    ev_any      = ev_drop | ev_dchg | ev_stall;
    drop_d      = clear ? '0 : (err_valid_drop  | ev_drop);
    dchg_d      = clear ? '0 : (err_data_change | ev_dchg);
    stall_err_d = clear ? '0 : (err_stall       | ev_stall);

    // Only the very first error event since reset/clear is recorded; lowest index wins ties.
    first_d = first_err_ch;
    if (clear) begin
      first_d = NONE;
    end else if (first_err_ch == NONE && |ev_any) begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (ev_any[i]) first_d = FW'(i);
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        stall_q[i] <= 8'd0;
        held_q[i]  <= '0;
      end
      xfer_count      <= '0;
      err_valid_drop  <= '0;
      err_data_change <= '0;
      err_stall       <= '0;
      err_any         <= 1'b0;
      first_err_ch    <= NONE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        stall_q[i] <= stall_d[i];
        held_q[i]  <= held_d[i];
      end
      xfer_count      <= count_d;
      err_valid_drop  <= drop_d;
      err_data_change <= dchg_d;
      err_stall       <= stall_err_d;
      err_any         <= |{drop_d, dchg_d, stall_err_d};
      first_err_ch    <= first_d;
    end
  end

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Bench for handshake_protocol_monitor: directed protocol scenarios followed by
// randomized traffic, all checked against a stall-length based reference model.
module tb_handshake_protocol_monitor;
  localparam int NUM_CH    = 3;
  localparam int DW        = 4;
  localparam int CW        = 16;
  localparam int MAX_STALL = 15;
  localparam int FW        = $clog2(NUM_CH) + 1;
  localparam int W         = NUM_CH * CW;
  localparam logic [FW-1:0] NONE = '1;

  logic                 CLK = 1'b0;
  logic                 ASYNCRESETN;
  logic                 clear;
  logic [NUM_CH-1:0]    valid, ready;
  logic [NUM_CH*DW-1:0] data;
  logic [W-1:0]         xfer_count;
  logic [NUM_CH-1:0]    err_valid_drop, err_data_change, err_stall;
  logic                 err_any;
  logic [FW-1:0]        first_err_ch;

  handshake_protocol_monitor #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_STALL(MAX_STALL)
  ) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clear(clear),
    .valid(valid), .ready(ready), .data(data),
    .xfer_count(xfer_count), .err_valid_drop(err_valid_drop),
    .err_data_change(err_data_change), .err_stall(err_stall),
    .err_any(err_any), .first_err_ch(first_err_ch)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Each channel is described by how many consecutive valid&!ready cycles it has
  // seen so far (0 = no stall outstanding) and the payload offered when it began.
  int              m_stall [NUM_CH];
  logic [DW-1:0]   m_held  [NUM_CH];
  logic [CW-1:0]   m_cnt   [NUM_CH];
  logic [NUM_CH-1:0] m_drop, m_dchg, m_st;
  logic [FW-1:0]   m_first;
  logic [W-1:0]    exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_stall[c] = 0;
      m_held[c]  = '0;
      m_cnt[c]   = '0;
    end
    m_drop = '0; m_dchg = '0; m_st = '0;
    m_first = NONE;
    exp_q.delete();
  endtask

  task automatic model_cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                             input logic [NUM_CH*DW-1:0] d, input logic clr);
    logic [NUM_CH-1:0] fresh;
    logic [W-1:0] packed_cnt;
    fresh = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [DW-1:0] dc;
      bit pend, e_drop, e_dchg, e_st;
      dc     = d[c*DW +: DW];
      pend   = (m_stall[c] > 0);
      e_drop = pend && !v[c];
      e_dchg = pend && v[c] && (dc != m_held[c]);
      e_st   = v[c] && !r[c] && (m_stall[c] + 1 > MAX_STALL);
      if (v[c] && !r[c]) begin
        if (!pend) m_held[c] = dc;
        m_stall[c]++;
      end else begin
        m_stall[c] = 0;
      end
      if (clr) m_cnt[c] = '0;
      else if (v[c] && r[c]) m_cnt[c] = m_cnt[c] + 1'b1;
      if (!clr) begin
        m_drop[c] = m_drop[c] | e_drop;
        m_dchg[c] = m_dchg[c] | e_dchg;
        m_st[c]   = m_st[c]   | e_st;
      end
      fresh[c] = e_drop | e_dchg | e_st;
    end
    if (clr) begin
      m_drop = '0; m_dchg = '0; m_st = '0;
      m_first = NONE;
    end else if (m_first == NONE) begin
      for (int c = 0; c < NUM_CH; c++)
        if (fresh[c] && m_first == NONE) m_first = FW'(c);
    end
    for (int c = 0; c < NUM_CH; c++) packed_cnt[c*CW +: CW] = m_cnt[c];
    exp_q.push_back(packed_cnt);
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_all(input string tag);
    logic [W-1:0] exp_cnt;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
      return;
    end
    exp_cnt = exp_q.pop_front();
    check({tag, "_xfer_count"}, 64'(xfer_count), 64'(exp_cnt));
    check({tag, "_err_valid_drop"}, 64'(err_valid_drop), 64'(m_drop));
    check({tag, "_err_data_change"}, 64'(err_data_change), 64'(m_dchg));
    check({tag, "_err_stall"}, 64'(err_stall), 64'(m_st));
    check({tag, "_err_any"}, 64'(err_any), 64'(|{m_drop, m_dchg, m_st}));
    check({tag, "_first_err_ch"}, 64'(first_err_ch), 64'(m_first));
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input string tag, input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                      input logic [NUM_CH*DW-1:0] d, input logic clr);
    valid = v; ready = r; data = d; clear = clr;
    model_cycle(v, r, d, clr);
    @(posedge CLK);
    #1;
    compare_all(tag);
  endtask

  function automatic logic [NUM_CH*DW-1:0] put(input int c, input logic [DW-1:0] x);
    logic [NUM_CH*DW-1:0] d;
    d = '0;
    d[c*DW +: DW] = x;
    return d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ASYNCRESETN = 1'b0;
    clear = 1'b0; valid = '0; ready = '0; data = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_xfer_count", 64'(xfer_count), 64'd0);
    check("reset_err_any", 64'(err_any), 64'd0);
    check("reset_first_err_ch", 64'(first_err_ch), 64'(NONE));
    ASYNCRESETN = 1'b1;
    step("idle0", 3'b000, 3'b101, '0, 1'b0);

    // ch0: three back-to-back transfers
    step("ch0_x1", 3'b001, 3'b001, put(0, 4'h1), 1'b0);
    step("ch0_x2", 3'b001, 3'b001, put(0, 4'h2), 1'b0);
    step("ch0_x3", 3'b001, 3'b001, put(0, 4'h3), 1'b0);
    check("plan_ch0_count3", 64'(xfer_count[CW-1:0]), 64'd3);
    check("plan_ch0_first_none", 64'(first_err_ch), 64'(NONE));
    step("idle1", 3'b000, 3'b000, '0, 1'b0);

    // ch1: legal 4-cycle stall then accept
    for (int k = 0; k < 4; k++) step("ch1_stall", 3'b010, 3'b000, put(1, 4'hA), 1'b0);
    step("ch1_accept", 3'b010, 3'b010, put(1, 4'hA), 1'b0);
    check("plan_ch1_count1", 64'(xfer_count[2*CW-1:CW]), 64'd1);
    check("plan_ch1_no_err", 64'(err_any), 64'd0);

    // ch2: payload changes on stall cycle 2
    step("ch2_stall1", 3'b100, 3'b000, put(2, 4'h5), 1'b0);
    step("ch2_change", 3'b100, 3'b000, put(2, 4'h6), 1'b0);
    check("plan_ch2_dchg", 64'(err_data_change[2]), 64'd1);
    check("plan_ch2_first", 64'(first_err_ch), 64'd2);
    step("ch2_accept", 3'b100, 3'b100, put(2, 4'h6), 1'b0);
    step("clear1", 3'b000, 3'b000, '0, 1'b1);

    // ch0: valid dropped on stall cycle 3, then a normal transfer
    step("ch0_st1", 3'b001, 3'b000, put(0, 4'h7), 1'b0);
    step("ch0_st2", 3'b001, 3'b000, put(0, 4'h7), 1'b0);
    step("ch0_drop", 3'b000, 3'b000, '0, 1'b0);
    check("plan_ch0_drop", 64'(err_valid_drop[0]), 64'd1);
    step("ch0_after", 3'b001, 3'b001, put(0, 4'h8), 1'b0);
    check("plan_ch0_count_after", 64'(xfer_count[CW-1:0]), 64'd1);
    step("clear2", 3'b000, 3'b000, '0, 1'b1);

    // ch1: stall-length boundary
    for (int k = 1; k <= MAX_STALL + 1; k++) begin
      step("ch1_long", 3'b010, 3'b000, put(1, 4'hC), 1'b0);
      if (k == MAX_STALL)     check("plan_stall_not_yet", 64'(err_stall[1]), 64'd0);
      if (k == MAX_STALL + 1) check("plan_stall_set", 64'(err_stall[1]), 64'd1);
    end
    step("ch1_long_more", 3'b010, 3'b000, put(1, 4'hC), 1'b0);
    step("ch1_long_end", 3'b010, 3'b010, put(1, 4'hC), 1'b0);

    // clear while ch2 is mid-stall: the stall keeps being checked
    step("ch2_pre", 3'b100, 3'b000, put(2, 4'h3), 1'b0);
    step("clear3", 3'b100, 3'b000, put(2, 4'h3), 1'b1);
    step("ch2_post", 3'b100, 3'b000, put(2, 4'h4), 1'b0);
    step("ch2_post_ok", 3'b100, 3'b100, put(2, 4'h3), 1'b0);
    step("clear4", 3'b000, 3'b000, '0, 1'b1);

    // simultaneous drops on ch1 and ch2
    step("dual_stall", 3'b110, 3'b000, put(1, 4'h2) | put(2, 4'h9), 1'b0);
    step("dual_drop", 3'b000, 3'b000, '0, 1'b0);
    check("plan_dual_first", 64'(first_err_ch), 64'd1);
    step("clear5", 3'b000, 3'b000, '0, 1'b1);
    check("plan_clear_flags", 64'({err_valid_drop, err_data_change, err_stall, err_any}), 64'd0);
    check("plan_clear_first", 64'(first_err_ch), 64'(NONE));

    // asynchronous reset in the middle of a stall
    step("rst_x", 3'b001, 3'b001, put(0, 4'h1), 1'b0);
    step("rst_st1", 3'b011, 3'b000, put(0, 4'h2) | put(1, 4'h3), 1'b0);
    step("rst_st2", 3'b011, 3'b000, put(0, 4'h5) | put(1, 4'h3), 1'b0);
    #1;
    ASYNCRESETN = 1'b0;
    #1;
    check("async_rst_count", 64'(xfer_count), 64'd0);
    check("async_rst_errs", 64'({err_valid_drop, err_data_change, err_stall, err_any}), 64'd0);
    check("async_rst_first", 64'(first_err_ch), 64'(NONE));
    valid = '0; ready = '0; data = '0; clear = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;
    step("post_rst_idle", 3'b000, 3'b000, '0, 1'b0);
    step("post_rst_x", 3'b011, 3'b011, put(0, 4'h1) | put(1, 4'h2), 1'b0);

    // randomized traffic, mostly protocol-legal with occasional violations and clears
    for (int n = 0; n < 600; n++) begin
      logic [NUM_CH-1:0] v, r;
      logic [NUM_CH*DW-1:0] d;
      d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_stall[c] > 0) begin
          v[c] = ($urandom_range(0, 15) != 0);
          d[c*DW +: DW] = ($urandom_range(0, 15) != 0) ? m_held[c] : DW'($urandom);
        end else begin
          v[c] = 1'($urandom_range(0, 1));
          d[c*DW +: DW] = DW'($urandom);
        end
        r[c] = ($urandom_range(0, 3) == 0);
      end
      step("rand", v, r, d, $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
